wb_uart_arb: RTL and testbench

Two-master Wishbone classic arbiter that shares the single UART slave port between the CPU data bus (master 0) and the DMA/debug bus (master 1). It registers a round-robin grant, holds ownership for the full bus cycle (`cyc` high), and muxes the granted master's request onto the slave and the slave's `ack`/data back to that master only. It sits between the interconnect address decoder and the `uart` peripheral instance.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_uart_arb_if.sv | 35 +++
 rtl/wb_rr_pick.sv | 22 ++
 rtl/wb_uart_arb.sv | 144 ++++++++++++++
 tb/tb_wb_uart_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone UART arbiter.
//   NUM_MASTERS  : number of requesting masters (fixed at 2)
//   TIMEOUT_DATA : read data returned to a master whose cycle was force-terminated
//   arb_state_e  : arbiter FSM states
package wb_arb_pkg;

    localparam int unsigned NUM_MASTERS  = 2;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/wb_uart_arb_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the UART slave.
// Masters' signals are packed: master i occupies bit i of the 2-bit vectors and
// bits [32i+31:32i] of the 64-bit vectors.
//   modport slave  : the arbiter's view (accepts master requests, drives the UART port)
//   modport master : the environment's view (masters + UART model)
interface wb_uart_arb_if;
    import wb_arb_pkg::*;

    logic [NUM_MASTERS-1:0]    m_cyc;
    logic [NUM_MASTERS-1:0]    m_stb;
    logic [NUM_MASTERS-1:0]    m_we;
    logic [32*NUM_MASTERS-1:0] m_addr;
    logic [32*NUM_MASTERS-1:0] m_data_i;
    logic [31:0]               m_data_o;
    logic [NUM_MASTERS-1:0]    m_ack;

    logic                      s_cyc;
    logic                      s_stb;
    logic                      s_we;
    logic [31:0]               s_addr;
    logic [31:0]               s_data_o;
    logic [31:0]               s_data_i;
    logic                      s_ack;

    modport slave (
        input  m_cyc, m_stb, m_we, m_addr, m_data_i, s_data_i, s_ack,
        output m_data_o, m_ack, s_cyc, s_stb, s_we, s_addr, s_data_o
    );

    modport master (
        output m_cyc, m_stb, m_we, m_addr, m_data_i, s_data_i, s_ack,
        input  m_data_o, m_ack, s_cyc, s_stb, s_we, s_addr, s_data_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational two-way round-robin selector.
//   req_i  : request vector, bit i = master i
//   last_i : index of the master that owned the bus most recently
//   win_o  : one-hot winner, 00 when nobody requests
module wb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        unique case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            // Tie: the master that did not go last wins.
            2'b11:   win_o = last_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_uart_arb.sv
// Two-master Wishbone classic arbiter in front of the single UART slave port.
// Registers a round-robin grant, keeps ownership while the owner holds cyc, and
// muxes the owner's request to the slave and the slave's ack/data back to it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : master request/response and slave port bundle (slave modport)
//   grant    : one-hot current owner, 00 when idle
//   timeout  : one-cycle pulse on forced termination
// Optional feature: define ARB_TIMEOUT_EN to force-terminate a strobe the slave
// leaves unacknowledged for TIMEOUT_CYCLES cycles (2..255). Without it timeout is 0.
module wb_uart_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_uart_arb_if.slave           bus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   last_q, last_d;
    logic [NUM_MASTERS-1:0] win;
    logic                   gi;

    logic                   s_cyc, s_stb, s_we;
    logic [31:0]            s_addr, s_data_o, m_data_o;
    logic [NUM_MASTERS-1:0] m_ack;
    logic                   to_fire;

    wb_rr_pick u_pick (
        .req_i  (bus.m_cyc),
        .last_i (last_q),
        .win_o  (win)
    );

    // grant_q is one-hot when busy, so its upper bit is the owner's index.
    assign gi = grant_q[1];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign to_fire = (state_q == StBusy) && (cnt_q == 8'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            // Held at zero while idle, so every BUSY entry starts from zero.
            cnt_d = 8'd0;
        end else if (to_fire || bus.s_ack) begin
            cnt_d = 8'd0;
        end else if (s_stb) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;

    logic [39:0] unused_cfg;
    assign unused_cfg = {8'(TIMEOUT_CYCLES), TIMEOUT_DATA};
`endif

    // Datapath mux, driven purely from the registered grant.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = 32'd0;
        s_data_o = 32'd0;
        m_ack    = '0;
        m_data_o = 32'd0;
        if (state_q == StBusy) begin
            s_cyc    = bus.m_cyc[gi];
            s_stb    = bus.m_stb[gi];
            s_we     = bus.m_we[gi];
            s_addr   = gi ? bus.m_addr[63:32]   : bus.m_addr[31:0];
            s_data_o = gi ? bus.m_data_i[63:32] : bus.m_data_i[31:0];
            m_ack    = bus.s_ack ? grant_q : '0;
            m_data_o = bus.s_data_i;
            if (to_fire) begin
                // Terminate the stalled strobe towards the slave and complete it
                // to the master with a recognisable error pattern.
                s_stb    = 1'b0;
                m_ack    = grant_q;
                m_data_o = TIMEOUT_DATA;
            end
        end
    end

    assign bus.s_cyc    = s_cyc;
    assign bus.s_stb    = s_stb;
    assign bus.s_we     = s_we;
    assign bus.s_addr   = s_addr;
    assign bus.s_data_o = s_data_o;
    assign bus.m_ack    = m_ack;
    assign bus.m_data_o = m_data_o;
    assign grant        = grant_q;
    assign timeout      = to_fire;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.m_cyc) begin
                    grant_d = win;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Release only; arbitration waits for the following idle cycle.
                if (!bus.m_cyc[gi]) begin
                    last_d  = gi;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_arb.sv
// Self-checking bench for wb_uart_arb: directed scenarios followed by a random
// phase, all compared against a behavioural model of the arbiter.
module tb_wb_uart_arb;
    import wb_arb_pkg::*;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       timeout;

    wb_uart_arb_if bus ();

    wb_uart_arb #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int errors = 0;

    // Model state: current owner index (-1 = none), last owner, stall count.
    int owner = -1;
    int last  = 1;
    int stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at negedge against the model, advance the
    // model at posedge, then leave 1 time unit for the caller to drive inputs.
    task automatic cycle(input string tag);
        logic [1:0]  e_grant, e_ack;
        logic [31:0] e_rd, e_addr, e_wd;
        logic        e_cyc, e_stb, e_we, e_to, fire;
        @(negedge clk);
        e_grant = 2'b00; e_ack = 2'b00; e_rd = 32'd0; e_addr = 32'd0; e_wd = 32'd0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0; fire = 1'b0;
        if (owner >= 0) begin
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            e_cyc   = bus.m_cyc[owner];
            e_stb   = bus.m_stb[owner];
            e_we    = bus.m_we[owner];
            e_addr  = (owner == 1) ? bus.m_addr[63:32] : bus.m_addr[31:0];
            e_wd    = (owner == 1) ? bus.m_data_i[63:32] : bus.m_data_i[31:0];
            e_ack   = bus.s_ack ? e_grant : 2'b00;
            e_rd    = bus.s_data_i;
`ifdef ARB_TIMEOUT_EN
            if (stall == int'(TO)) begin
                fire  = 1'b1;
                e_stb = 1'b0;
                e_ack = e_grant;
                e_rd  = TIMEOUT_DATA;
                e_to  = 1'b1;
            end
`endif
        end
        chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
        chk({tag, ".m_ack"}, 32'(bus.m_ack), 32'(e_ack));
        chk({tag, ".m_data_o"}, bus.m_data_o, e_rd);
        chk({tag, ".s_ctl"}, 32'({bus.s_cyc, bus.s_stb, bus.s_we}), 32'({e_cyc, e_stb, e_we}));
        chk({tag, ".s_addr"}, bus.s_addr, e_addr);
        chk({tag, ".s_data_o"}, bus.s_data_o, e_wd);
        chk({tag, ".timeout"}, 32'(timeout), 32'(e_to));
        @(posedge clk);
        if (rst) begin
            owner = -1;
            last  = 1;
        end else if (owner < 0) begin
            if (bus.m_cyc != 2'b00) begin
                if (bus.m_cyc == 2'b11) owner = 1 - last;
                else                    owner = bus.m_cyc[1] ? 1 : 0;
                stall = 0;
            end
        end else if (!bus.m_cyc[owner]) begin
            last  = owner;
            owner = -1;
        end else if (fire || bus.s_ack) begin
            stall = 0;
        end else if (bus.m_stb[owner]) begin
            stall++;
        end
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        bus.m_cyc[i] = c;
        bus.m_stb[i] = s;
        bus.m_we[i]  = w;
        if (i == 1) begin
            bus.m_addr[63:32] = a; bus.m_data_i[63:32] = d;
        end else begin
            bus.m_addr[31:0] = a;  bus.m_data_i[31:0] = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.s_ack = 1'b0; bus.s_data_i = 32'd0;
        cycle("rst");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.s_ack = 1'b0; bus.s_data_i = 32'd0;
        @(posedge clk); #1;

        // Reset, idle, then a single m0 write of 0x41.
        do_reset();
        cycle("idle");
        chk("idle_grant", 32'(grant), 32'd0);
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0041);
        cycle("a_req");
        chk("a_grant", 32'(grant), 32'h1);
        bus.s_ack = 1'b1; #1;
        chk("a_ack", 32'(bus.m_ack), 32'h1);
        chk("a_sdata", bus.s_data_o, 32'h41);
        cycle("a_ack");
        bus.s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("a_rel");
        chk("a_rel_grant", 32'(grant), 32'd0);
        cycle("a_idle");

        // Repeated ties from reset alternate 0,1,0,1 with one idle cycle between.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hA0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            cycle("tie_req");
            chk("tie_grant", 32'(grant), (i % 2 == 1) ? 32'h2 : 32'h1);
            bus.s_ack = 1'b1;
            cycle("tie_ack");
            bus.s_ack = 1'b0;
            bus.m_cyc[i % 2] = 1'b0;
            cycle("tie_rel");
            chk("tie_gap", 32'(grant), 32'd0);
            bus.m_cyc[i % 2] = 1'b1;
        end

        // m1 holds cyc for 3 read strobes while m0 waits; read data 0x55.
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        cycle("h_req");
        chk("h_grant", 32'(grant), 32'h2);
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h77);
        for (int i = 0; i < 3; i++) begin
            bus.s_ack = 1'b1; bus.s_data_i = 32'h0000_0055; #1;
            chk("h_rd_data", bus.m_data_o, 32'h55);
            chk("h_rd_ack", 32'(bus.m_ack), 32'h2);
            cycle("h_ack");
            bus.s_ack = 1'b0; bus.s_data_i = 32'd0; #1;
            chk("h_rd_zero", bus.m_data_o, 32'd0);
            cycle("h_wait");
        end
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("h_rel");
        cycle("h_gap");
        chk("h_m0_grant", 32'(grant), 32'h1);
        bus.s_ack = 1'b1;
        cycle("h_m0_ack");
        bus.s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("h_m0_rel");

        // Reset while a strobe is being acknowledged.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h99);
        cycle("r_req");
        bus.s_ack = 1'b1; rst = 1'b1;
        cycle("r_rst");
        chk("r_grant", 32'(grant), 32'd0);
        chk("r_scyc", 32'(bus.s_cyc), 32'd0);
        chk("r_mack", 32'(bus.m_ack), 32'd0);
        rst = 1'b0;
        bus.s_ack = 1'b0;

        // Slave that never acks.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
        cycle("t_req");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) cycle("t_stall");
        chk("t_pulse", 32'(timeout), 32'h1);
        chk("t_ack", 32'(bus.m_ack), 32'h1);
        chk("t_data", bus.m_data_o, TIMEOUT_DATA);
        cycle("t_fire");
        chk("t_after", 32'(timeout), 32'd0);
        chk("t_keep", 32'(grant), 32'h1);
`else
        for (int i = 0; i < 20; i++) cycle("t_stall");
        chk("t_noto", 32'(timeout), 32'd0);
        chk("t_noack", 32'(bus.m_ack), 32'd0);
        chk("t_keep", 32'(grant), 32'h1);
`endif
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("t_rel");

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(63) == 0);
            for (int i = 0; i < 2; i++) begin
                logic c;
                c = bus.m_cyc[i];
                if (c) begin
                    if ($urandom_range(3) == 0) c = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    c = 1'b1;
                end
                set_m(i, c, c & 1'($urandom_range(1)), 1'($urandom_range(1)),
                      $urandom(), $urandom());
            end
            bus.s_ack    = 1'($urandom_range(1));
            bus.s_data_i = bus.s_ack ? $urandom() : 32'd0;
            cycle("rnd");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
